if_fetch_stage: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Issues the current fetch

---
 rtl/if_fetch_stage_pkg.sv | 21 ++
 rtl/if_fetch_stage_buf.sv | 54 +++++
 rtl/if_fetch_stage.sv | 135 +++++++++++++
 tb/tb_if_fetch_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] START_POINT = 32'h8000_0000;

  typedef enum logic {
    IF_REQ,
    IF_WAIT
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } if_entry_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_buf.sv
// Two-entry FIFO of fetched {pc, inst, adel}; head is presented to decode.
module if_buf2
  import if_fetch_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  if_entry_t din,
  output if_entry_t head,
  output logic [1:0] count
);

  if_entry_t e0, e1;
  logic      do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = e0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new word lands behind the survivor.
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues fetches on an addr_ok/data_ok bus, buffers words,
// and drives the PC register update (sequential or redirect).
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC  = START_POINT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  output logic [31:0] pc_in,
  output logic        pc_we,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  if_state_e   state, state_next;
  logic        cancel, cancel_next;
  logic        stall, stall_next;
  logic [31:0] inflight_pc;
  logic        capture;
  logic        req, we;
  logic [31:0] pc_sel;
  logic        push, pop, free;
  if_entry_t   push_entry, head;
  logic [1:0]  count;

  assign free = count < 2'(BUF_DEPTH);
  assign pop  = id_valid && id_allowin;

  always_comb begin
    state_next  = state;
    cancel_next = cancel;
    stall_next  = stall;
    req         = 1'b0;
    we          = 1'b0;
    pc_sel      = npc;
    push        = 1'b0;
    push_entry  = '0;
    capture     = 1'b0;

    unique case (state)
      IF_REQ: begin
        if (br_taken) begin
          // A request accepted alongside a redirect is still outstanding on the bus.
          if (inst_addr_ok) begin
            state_next  = IF_WAIT;
            cancel_next = 1'b1;
            capture     = 1'b1;
          end
        end else if (is_misaligned(pc)) begin
          if (!stall && free) begin
            push       = 1'b1;
            push_entry = '{pc: pc, inst: '0, adel: 1'b1};
            we         = 1'b1;
            stall_next = 1'b1;
          end
        end else if (free) begin
          req = 1'b1;
          if (inst_addr_ok) begin
            we         = 1'b1;
            capture    = 1'b1;
            state_next = IF_WAIT;
          end
        end
      end
      IF_WAIT: begin
        if (inst_data_ok) begin
          state_next  = IF_REQ;
          cancel_next = 1'b0;
          if (!cancel && !br_taken) begin
            push       = 1'b1;
            push_entry = '{pc: inflight_pc, inst: inst_rdata, adel: 1'b0};
          end
        end else if (br_taken) begin
          cancel_next = 1'b1;
        end
      end
      default: state_next = IF_REQ;
    endcase

    if (br_taken) begin
      we         = 1'b1;
      pc_sel     = br_target;
      stall_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IF_REQ;
      cancel      <= 1'b0;
      stall       <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state  <= state_next;
      cancel <= cancel_next;
      stall  <= stall_next;
      if (capture) inflight_pc <= pc;
    end
  end

  if_buf2 u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (br_taken),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign inst_req  = req && !rst;
  assign inst_addr = inst_req ? pc : '0;
  assign pc_we     = we && !rst;
  assign pc_in     = rst ? RESET_PC : pc_sel;
  assign id_valid  = count != 2'd0;
  assign id_pc     = head.pc;
  assign id_inst   = head.inst;
  assign id_adel   = head.adel;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a PC register and bus slave around the DUT,
// with a program-order model of the instruction stream seen by decode.
module tb_if_fetch_stage;

  localparam logic [31:0] BOOT_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc, npc, pc_in;
  logic        pc_we;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        id_allowin = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc, id_inst;
  logic        id_adel;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc;
  bit          stalled;
  bit          busy;
  int          lat;
  logic [31:0] bus_addr;

  if_fetch_stage #(.BUF_DEPTH(2), .RESET_PC(BOOT_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .npc          (npc),
    .pc_in        (pc_in),
    .pc_we        (pc_we),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_allowin   (id_allowin),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_adel      (id_adel)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pc <= BOOT_PC;
    else if (pc_we) pc <= pc_in;
  end
  assign npc = pc + 32'd4;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic do_reset();
    rst = 1'b1;
    br_taken = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; id_allowin = 1'b0;
    #1;
    check("rst_inst_req", 32'(inst_req), 32'd0);
    check("rst_pc_we",    32'(pc_we),    32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_pc_in",    pc_in,         BOOT_PC);
    check("rst_id_pc",    id_pc,         32'd0);
    check("rst_inst_addr", inst_addr,    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pc  = BOOT_PC;
    stalled = 1'b0;
  endtask

  task automatic cycle(input bit br, input logic [31:0] tgt, input bit allow, input bit force_aok);
    bit was_busy;
    logic adel;
    br_taken = br; br_target = tgt; id_allowin = allow;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    was_busy = busy;
    #1;
    if (busy) begin
      if (lat <= 1) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem(bus_addr);
        busy         = 1'b0;
      end else begin
        lat--;
      end
    end
    #1;
    if (inst_req) check("req_addr", inst_addr, pc);
    if (pc[1:0] != 2'b00) check("misaligned_no_req", 32'(inst_req), 32'd0);
    if (!was_busy && ((inst_req && $urandom_range(0, 3) != 0) || force_aok)) begin
      inst_addr_ok = 1'b1;
      busy     = 1'b1;
      bus_addr = inst_addr;
      lat      = int'($urandom_range(1, 3));
    end
    #1;
    if (id_valid && allow) begin
      if (stalled) begin
        check("pop_after_adel", 32'(id_valid), 32'd0);
      end else begin
        adel = exp_pc[1:0] != 2'b00;
        check("id_pc",   id_pc,         exp_pc);
        check("id_adel", 32'(id_adel),  32'(adel));
        check("id_inst", id_inst,       adel ? 32'd0 : mem(exp_pc));
        if (adel) stalled = 1'b1;
        else      exp_pc  = exp_pc + 32'd4;
      end
    end
    if (br) begin
      exp_pc  = tgt;
      stalled = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n, input int allow_pct);
    for (int i = 0; i < n; i++)
      cycle(1'b0, '0, $urandom_range(0, 99) < allow_pct, 1'b0);
  endtask

  initial begin
    logic [31:0] tgt;
    busy = 1'b0;
    lat  = 0;
    do_reset();

    #1;
    check("first_req",  32'(inst_req), 32'd1);
    check("first_addr", inst_addr,     BOOT_PC);
    run(20, 100);

    run(8, 0);
    check("full_no_req", 32'(inst_req), 32'd0);
    check("full_valid",  32'(id_valid), 32'd1);
    run(12, 100);

    for (int i = 0; i < 20 && !busy; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("wait_reached", 32'(busy), 32'd1);
    lat = 2;
    cycle(1'b1, 32'h8000_1000, 1'b1, 1'b0);
    check("redir_flush", 32'(id_valid), 32'd0);
    run(12, 100);

    for (int i = 0; i < 20 && busy; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("bus_idle", 32'(busy), 32'd0);
    cycle(1'b1, 32'h8000_2000, 1'b1, 1'b1);
    check("aok_redir_flush", 32'(id_valid), 32'd0);
    run(12, 100);

    cycle(1'b1, 32'h8000_0002, 1'b1, 1'b0);
    run(10, 100);
    check("adel_stall_req", 32'(inst_req), 32'd0);
    check("adel_stall_pc_we", 32'(pc_we), 32'd0);
    cycle(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
    run(12, 100);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 6) begin
        tgt = $urandom;
        if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
        cycle(1'b1, tgt, $urandom_range(0, 99) < 70, 1'b0);
      end else begin
        cycle(1'b0, '0, $urandom_range(0, 99) < 70, 1'b0);
      end
    end

    for (int i = 0; i < 20 && !busy; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("wait_before_rst", 32'(busy), 32'd1);
    lat = 1;
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("late_data_dropped", 32'(id_valid), 32'd0);
    run(16, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
